// File: rtl/poly_mul_array.sv
// poly_mul_array: LANES parallel modular multiplier lanes computing
// r_i = a_i * b^ROUNDS mod Q with Barrett reduction.
// Each round is MUL -> RED -> SUB (3 cycles), and latency is data-independent.
// Optional feature macro: POLY_MUL_LANE_MASK_EN adds a per-lane enable input
// (lane_en). It is latched at start, and masked lanes hold all of their registers at 0.
module poly_mul_array #(
  parameter int LANES  = 100,
  parameter int W      = 12,
  parameter int Q      = 3329,
  parameter int ROUNDS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LANES*W-1:0] a_vec,
  input  logic [W-1:0]       b,
`ifdef POLY_MUL_LANE_MASK_EN
  input  logic [LANES-1:0]   lane_en,
`endif
  output logic               busy,
  output logic               done,
  output logic [LANES*W-1:0] result
);

  // Barrett constants: K = 2W covers any W x W product, M = floor(2^K / Q).
  localparam int             K     = 2 * W;
  localparam int             CW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [K:0]     ONE_K = {1'b1, {K{1'b0}}};
  localparam logic [K:0]     Q_K   = (K+1)'(Q);
  localparam logic [K:0]     M     = ONE_K / Q_K;
  localparam logic [W:0]     Q_W1  = (W+1)'(Q);
  localparam logic [CW-1:0]  LAST  = CW'(ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, MUL, RED, SUB, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    b_q;
  logic            accept;
  logic [LANES-1:0] load_en;  // lane activity applied at start acceptance
  logic [LANES-1:0] act;      // lane activity during the operation

  assign accept = (state_q == IDLE) && start;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

`ifdef POLY_MUL_LANE_MASK_EN
  logic [LANES-1:0] en_q;

  // Latch the lane mask together with the operands.
  always_ff @(posedge clk) begin
    if (!rst_n)      en_q <= '0;
    else if (accept) en_q <= lane_en;
  end

  assign load_en = lane_en;
  assign act     = en_q;
`else
  assign load_en = '1;
  assign act     = '1;
`endif

  // State register, round counter and shared operand latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) b_q <= b;
    end
  end

  // Next-state logic: start is only honoured in IDLE, never queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = MUL;
        cnt_d   = '0;
      end
      MUL:  state_d = RED;
      RED:  state_d = SUB;
      SUB:  if (cnt_q == LAST) begin
        state_d = DONE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = MUL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0]   r_q;
    logic [K-1:0]   p_q;
    logic [W:0]     u_q;
    logic [4*W:0]   pm;
    logic [W:0]     t_lo;
    logic [W:0]     u_d;
    logic [W-1:0]   r_d;

    // t = (p*M) >> K underestimates floor(p/Q) by at most one, so u < 2Q
    // and the subtraction is exact modulo 2^(W+1).
    assign pm   = (4*W+1)'(p_q) * (4*W+1)'(M);
    assign t_lo = (W+1)'(pm >> K);
    assign u_d  = p_q[W:0] - t_lo * Q_W1;
    assign r_d  = W'((u_q >= Q_W1) ? (u_q - Q_W1) : u_q);

    // Per-lane datapath: one register updates per state; masked lanes stay 0.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q <= '0;
        p_q <= '0;
        u_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            r_q <= load_en[gi] ? a_vec[gi*W +: W] : '0;
            if (!load_en[gi]) begin
              p_q <= '0;
              u_q <= '0;
            end
          end
          MUL:     p_q <= act[gi] ? (K'(r_q) * K'(b_q)) : '0;
          RED:     u_q <= act[gi] ? u_d : '0;
          SUB:     r_q <= act[gi] ? r_d : '0;
          default: ;
        endcase
      end
    end

    assign result[gi*W +: W] = r_q;
  end

endmodule

// File: tb/tb_poly_mul_array.sv
// Self-checking bench for poly_mul_array: two instances (ROUNDS=1 and
// ROUNDS=4) share operands. Results are compared against a plain
// modular-exponentiation model, and handshake timing is checked cycle by cycle.
module tb_poly_mul_array;
  localparam int W  = 12;
  localparam int Q  = 3329;
  localparam int LN = 4;
  localparam int RW = LN * W;

  logic          clk = 1'b0;
  logic          rst_n, start1, start4;
  logic [RW-1:0] a_vec;
  logic [W-1:0]  b;
  logic          busy1, done1, busy4, done4;
  logic [RW-1:0] res1, res4;
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  poly_mul_array #(.LANES(LN), .W(W), .Q(Q), .ROUNDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_vec(a_vec), .b(b),
`ifdef POLY_MUL_LANE_MASK_EN
    .lane_en({LN{1'b1}}),
`endif
    .busy(busy1), .done(done1), .result(res1)
  );

  poly_mul_array #(.LANES(LN), .W(W), .Q(Q), .ROUNDS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_vec(a_vec), .b(b),
`ifdef POLY_MUL_LANE_MASK_EN
    .lane_en({LN{1'b1}}),
`endif
    .busy(busy4), .done(done4), .result(res4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: repeated multiply then reduce with the % operator.
  function automatic logic [RW-1:0] model(input logic [RW-1:0] av, input int bv, input int rounds);
    logic [RW-1:0] res;
    longint        r;
    res = '0;
    for (int i = 0; i < LN; i++) begin
      r = longint'(av[i*W +: W]);
      for (int k = 0; k < rounds; k++) r = (r * bv) % Q;
      res[i*W +: W] = W'(r);
    end
    return res;
  endfunction

  function automatic logic [RW-1:0] rand_ops();
    logic [RW-1:0] v;
    for (int i = 0; i < LN; i++) v[i*W +: W] = W'($urandom_range(Q - 1));
    return v;
  endfunction

  // One transaction: start, then watch 3*rounds+6 cycles sampled at negedge.
  task automatic run(input bit sel4, input int rounds, input bit inject,
                     input logic [W-1:0] bv, input string tag);
    logic [RW-1:0] exp, res_at, a_at, rs;
    logic          bz, dn;
    int            done_cnt, done_at, busy_cnt;
    done_cnt = 0;
    done_at  = -1;
    busy_cnt = 0;
    res_at   = '0;
    a_at     = a_vec;
    exp      = model(a_vec, int'(bv), rounds);
    b        = bv;
    if (sel4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    for (int k = 0; k < 3*rounds + 6; k++) begin
      bz = sel4 ? busy4 : busy1;
      dn = sel4 ? done4 : done1;
      rs = sel4 ? res4  : res1;
      if (bz) busy_cnt++;
      if (dn) begin
        done_cnt++;
        done_at = k;
        res_at  = rs;
      end
      if (k < 2)  check({tag, "/pre_sub"}, rs, a_at);
      if (k == 0) check({tag, "/busy_rise"}, bz, 1);
      if (inject && (k == 1 || k == 3*rounds)) begin
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0;
        start4 = 1'b0;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    start4 = 1'b0;
    check({tag, "/done_count"}, done_cnt, 1);
    check({tag, "/done_cycle"}, done_at, 3*rounds);
    check({tag, "/busy_cycles"}, busy_cnt, 3*rounds + 1);
    check({tag, "/result_at_done"}, res_at, exp);
    check({tag, "/result_held"}, sel4 ? res4 : res1, exp);
    $display("txn %s rounds=%0d b=%0d result=%0h expected=%0h", tag, rounds, bv, res_at, exp);
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    a_vec  = rand_ops();
    b      = '0;
    repeat (2) @(negedge clk);
    check("rst/busy1", busy1, 0);
    check("rst/done1", done1, 0);
    check("rst/busy4", busy4, 0);
    check("rst/done4", done4, 0);
    check("rst/res1", res1, 0);
    check("rst/res4", res4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // (Q-1)*(Q-1) mod Q = 1 on lane 0.
    a_vec = rand_ops();
    a_vec[W-1:0] = W'(3328);
    run(1'b0, 1, 1'b0, W'(3328), "r1_max");
    check("r1_max/lane0", res1[W-1:0], 1);

    // b = 0 clears every lane; fields show a_i before the first SUB.
    a_vec = {LN{W'(1234)}};
    run(1'b0, 1, 1'b0, W'(0), "r1_bzero");

    // Four rounds: 2*3^4 = 162 on lane 0.
    a_vec = rand_ops();
    a_vec[W-1:0] = W'(2);
    run(1'b1, 4, 1'b0, W'(3), "r4_small");
    check("r4_small/lane0", res4[W-1:0], 162);

    a_vec = rand_ops();
    a_vec[2*W-1:W] = W'(3000);
    run(1'b1, 4, 1'b0, W'(2000), "r4_3000x2000");

    // Starts at E0+2 and during DONE must be ignored.
    a_vec = rand_ops();
    run(1'b0, 1, 1'b1, W'($urandom_range(Q - 1)), "r1_inject");
    a_vec = rand_ops();
    run(1'b1, 4, 1'b1, W'($urandom_range(Q - 1)), "r4_inject");

    // Random sweeps on both instances.
    for (int n = 0; n < 4; n++) begin
      a_vec = rand_ops();
      run(1'b0, 1, 1'b0, W'($urandom_range(Q - 1)), "r1_rand");
      a_vec = rand_ops();
      run(1'b1, 4, 1'b0, W'($urandom_range(Q - 1)), "r4_rand");
    end

    // Reset mid-operation (sampled at E0+4), then an immediate fresh start.
    a_vec  = rand_ops();
    b      = W'($urandom_range(Q - 1));
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst/busy", busy4, 0);
    check("midrst/done", done4, 0);
    check("midrst/result", res4, 0);
    $display("txn midrst busy=%0b done=%0b result=%0h", busy4, done4, res4);
    rst_n = 1'b1;
    a_vec = rand_ops();
    run(1'b1, 4, 1'b0, W'($urandom_range(Q - 1)), "r4_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
